// File: rtl/spi_mem_resp.sv
// SPI memory responder: a frame is cs low, a wr bit, addr[7:0] and 8 data bits, all MSB first.
// Writes land in a local byte array; reads return a byte on miso over the next 8 sclk falling edges.
module spi_mem_resp #(
    parameter int MEM_DEPTH   = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs,
    input  logic mosi,
    output logic miso,
    output logic mem_ready,
    output logic mem_done,
    output logic frame_err
);
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, FIN} state_t;

    state_t r_state;
    state_t w_stateNext;

    logic [SYNC_STAGES-1:0] r_sclkSync;
    logic [SYNC_STAGES-1:0] r_csSync;
    logic [SYNC_STAGES-1:0] r_mosiSync;
    logic [SYNC_STAGES:0]   w_sclkChain;
    logic [SYNC_STAGES:0]   w_csChain;
    logic [SYNC_STAGES:0]   w_mosiChain;
    logic                   r_sclkPrev;
    logic                   w_sclk;
    logic                   w_cs;
    logic                   w_mosi;
    logic                   w_rise;
    logic                   w_fall;

    logic [3:0]    r_bitCnt;
    logic [7:0]    r_cmdShift;
    logic [8:0]    w_cmdNext;
    logic [7:0]    r_rxShift;
    logic [7:0]    r_txShift;
    logic [AW-1:0] r_wrIdx;
    logic          r_oor;
    logic          r_wrPending;
    logic          r_miso;
    logic          r_memReady;
    logic          r_memDone;
    logic          r_frameErr;
    logic [7:0]    r_mem [0:MEM_DEPTH-1];

    logic       w_active;
    logic       w_abort;
    logic       w_cmdDone;
    logic       w_dataDone;
    logic       w_loadTx;
    logic       w_addrOor;
    logic [7:0] w_rdByte;

    assign w_sclkChain = {r_sclkSync, sclk};
    assign w_csChain   = {r_csSync, cs};
    assign w_mosiChain = {r_mosiSync, mosi};
    assign w_sclk      = w_sclkChain[SYNC_STAGES];
    assign w_cs        = w_csChain[SYNC_STAGES];
    assign w_mosi      = w_mosiChain[SYNC_STAGES];
    assign w_rise      = w_sclk & ~r_sclkPrev;
    assign w_fall      = ~w_sclk & r_sclkPrev;
    assign w_cmdNext   = {r_cmdShift, w_mosi};
    assign w_addrOor   = (32'(w_cmdNext[7:0]) >= 32'(MEM_DEPTH));
    assign w_rdByte    = w_addrOor ? 8'h00 : r_mem[AW'(w_cmdNext[7:0])];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // A cs rise anywhere inside a frame aborts straight back to IDLE.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (!w_cs) w_stateNext = CMD;
            end
            CMD: begin
                if (w_cs) w_stateNext = IDLE;
                else if (w_rise && (r_bitCnt == 4'd8)) w_stateNext = w_cmdNext[8] ? WDATA : RDATA;
            end
            WDATA, RDATA: begin
                if (w_cs) w_stateNext = IDLE;
                else if (w_rise && (r_bitCnt == 4'd7)) w_stateNext = FIN;
            end
            FIN: begin
                if (w_cs) w_stateNext = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_comb begin
        w_active   = (r_state == CMD) || (r_state == WDATA) || (r_state == RDATA);
        w_abort    = w_active && w_cs;
        w_cmdDone  = (r_state == CMD) && !w_cs && w_rise && (r_bitCnt == 4'd8);
        w_dataDone = ((r_state == WDATA) || (r_state == RDATA)) && !w_cs && w_rise && (r_bitCnt == 4'd7);
        w_loadTx   = w_cmdDone && !w_cmdNext[8];
        miso       = (r_state == RDATA) ? r_miso : 1'b0;
        mem_ready  = r_memReady;
        mem_done   = r_memDone;
        frame_err  = r_frameErr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sclkSync  <= '0;
            r_csSync    <= '1;
            r_mosiSync  <= '0;
            r_sclkPrev  <= 1'b0;
            r_bitCnt    <= 4'd0;
            r_cmdShift  <= 8'd0;
            r_rxShift   <= 8'd0;
            r_txShift   <= 8'd0;
            r_wrIdx     <= '0;
            r_oor       <= 1'b0;
            r_wrPending <= 1'b0;
            r_miso      <= 1'b0;
            r_memReady  <= 1'b0;
            r_memDone   <= 1'b0;
            r_frameErr  <= 1'b0;
        end else begin
            r_sclkSync  <= w_sclkChain[SYNC_STAGES-1:0];
            r_csSync    <= w_csChain[SYNC_STAGES-1:0];
            r_mosiSync  <= w_mosiChain[SYNC_STAGES-1:0];
            r_sclkPrev  <= w_sclk;
            r_memDone   <= w_dataDone;
            r_frameErr  <= w_abort || (w_dataDone && r_oor);
            r_wrPending <= w_dataDone && (r_state == WDATA) && !r_oor;
            // Ready tracks the state and synchronized cs that will hold next cycle.
            r_memReady  <= (w_stateNext == IDLE) && w_csChain[SYNC_STAGES-1];

            if (w_stateNext != r_state) r_bitCnt <= 4'd0;
            else if (w_active && w_rise) r_bitCnt <= r_bitCnt + 4'd1;

            if ((r_state == CMD) && w_rise) r_cmdShift <= w_cmdNext[7:0];
            if (w_cmdDone) begin
                r_wrIdx <= AW'(w_cmdNext[7:0]);
                r_oor   <= w_addrOor;
            end

            if ((r_state == WDATA) && w_rise) r_rxShift <= {r_rxShift[6:0], w_mosi};

            if (w_loadTx) r_txShift <= w_rdByte;
            else if ((r_state == RDATA) && w_fall) r_txShift <= {r_txShift[6:0], 1'b0};

            if (r_state != RDATA) r_miso <= 1'b0;
            else if (w_fall) r_miso <= r_txShift[7];
        end
    end

    // The assembled byte is committed the cycle after the last data bit, unless reset intervenes.
    always_ff @(posedge clk) begin
        if (rst_n && r_wrPending) r_mem[r_wrIdx] <= r_rxShift;
    end
endmodule
